wb_stage: RTL

- Writeback stage of the RV32I pipeline; sits directly upstream of the register file write port (we/waddr/wdata).
- Accepts retiring instructions from the MEM stage and holds loads until the memory read response arrives.
- Aligns and sign- or zero-extends load data, drives one registered write per retired instruction, and raises a pipeline stall while a load is outstanding.
- Keeps a retired-instruction counter.

---
 rtl/wb_stage.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module   : wb_stage
//  Brief    : RV32I writeback stage. Retires instructions from MEM, holds
//             loads until the memory read response arrives, aligns and
//             extends load data, and drives one registered regfile write per
//             retirement. Keeps a retired-instruction counter and a sticky
//             protocol/format error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_we,
    input  logic [REG_ADDR_W-1:0] in_waddr,
    input  logic [XLEN-1:0]       in_wdata,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wdata,
    output logic                  stall_req,
    output logic [CNT_W-1:0]      instret,
    output logic                  err
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [REG_ADDR_W-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [CNT_W-1:0]        instret_q, instret_d;
    logic                    err_q, err_d;
    // Pending-load context captured at accept time.
    logic                    intent_q, intent_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [1:0]              addr_lo_q, addr_lo_d;

    logic                    w_accept;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [XLEN-1:0]         w_ld_data;
    logic                    w_fmt_ok;
    logic                    w_misalign;

    // Accept only when running, out of reset and not waiting on memory.
    assign in_ready  = rdy & rst & (state_q == S_IDLE);
    assign w_accept  = in_valid & in_ready;
    assign stall_req = (state_q == S_WAIT_MEM);

    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign instret = instret_q;
    assign err     = err_q;

    // Byte picked by the full byte offset, halfword by offset bit 1 only, so a
    // misaligned halfword still returns the enclosing aligned halfword.
    assign w_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    assign w_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    // Load data alignment/extension and format checking.
    always_comb begin
        w_ld_data  = '0;
        w_fmt_ok   = 1'b1;
        w_misalign = 1'b0;
        case (funct3_q)
            3'b000: w_ld_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001: begin
                w_ld_data  = {{(XLEN-16){w_half[15]}}, w_half};
                w_misalign = addr_lo_q[0];
            end
            3'b010: begin
                w_ld_data  = mem_rdata;
                w_misalign = |addr_lo_q;
            end
            3'b100: w_ld_data = {{(XLEN-8){1'b0}}, w_byte};
            3'b101: begin
                w_ld_data  = {{(XLEN-16){1'b0}}, w_half};
                w_misalign = addr_lo_q[0];
            end
            default: w_fmt_ok = 1'b0;
        endcase
    end

    // Next-state and registered-output logic; we defaults low so it pulses.
    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        instret_d = instret_q;
        err_d     = err_q;
        intent_d  = intent_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        case (state_q)
            S_IDLE: begin
                if (mem_rvalid) begin
                    err_d = 1'b1;
                end
                if (w_accept) begin
                    waddr_d = in_waddr;
                    if (in_is_load) begin
                        intent_d  = in_we;
                        funct3_d  = in_funct3;
                        addr_lo_d = in_addr_lo;
                        state_d   = S_WAIT_MEM;
                    end else begin
                        we_d      = in_we & (|in_waddr);
                        wdata_d   = in_wdata;
                        instret_d = instret_q + C_CNT_ONE;
                    end
                end
            end
            S_WAIT_MEM: begin
                if (mem_rvalid) begin
                    we_d      = intent_q & (|waddr_q) & w_fmt_ok;
                    wdata_d   = w_ld_data;
                    instret_d = instret_q + C_CNT_ONE;
                    if (!w_fmt_ok || w_misalign) begin
                        err_d = 1'b1;
                    end
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; rdy=0 freezes everything, including the we pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            instret_q <= '0;
            err_q     <= 1'b0;
            intent_q  <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
        end else if (rdy) begin
            state_q   <= state_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            instret_q <= instret_d;
            err_q     <= err_d;
            intent_q  <= intent_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

endmodule
`default_nettype wire
